fbc_cache_arb: RTL

Parametrised feedback-channel cache and arbiter for the timing board. It accepts CH_NUM independent feedback sample streams (FBCi, FBCr1, FBCr2, … ), stamps each sample with the encoder position, and buffers it in a per-channel FIFO. A round-robin arbiter drains the FIFOs into one wide cache word stream toward the aurora uplink, with per-channel backpressure and overflow accounting. It generalises the fixed three-channel FBC cache path to N channels, configurable widths and depth.

---
 rtl/fbc_cache_arb.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/fbc_cache_arb.sv
// Feedback-channel cache and arbiter: per-channel sample FIFOs stamped with
// encoder position and sequence number, drained round-robin into one wide
// cache word stream with per-channel backpressure and sticky drop flags.

// Per-channel record FIFO with synchronous flush and drop reporting.
module fbc_cache_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         drop_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full, wr_en, rd_en;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign rd_en   = pop_i & ~empty_o;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign wr_en   = push_i & (~full | rd_en) & ~flush_i;
    assign drop_o  = push_i & full & ~rd_en & ~flush_i;
    assign dout_o  = mem_q[rd_ptr_q];

    // Next pointer/level; flush empties the FIFO regardless of traffic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
            if (wr_en && !rd_en) cnt_d = cnt_q + (AW+1)'(1);
            else if (!wr_en && rd_en) cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents need no reset since the level gates reads.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= din_i;
    end
endmodule

// Top: sample capture, per-channel FIFOs, round-robin drain.
module fbc_cache_arb #(
    parameter int  CH_NUM = 3,
    parameter int  DATA_W = 48,
    parameter int  ENC_W  = 32,
    parameter int  DEPTH  = 16,
    parameter int  OUT_W  = 256,
    parameter real TCQ    = 0.1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [CH_NUM-1:0]        fbc_vld_i,
    input  logic [CH_NUM*DATA_W-1:0] fbc_data_i,
    input  logic [ENC_W-1:0]         encode_w_i,
    input  logic [ENC_W-1:0]         encode_x_i,
    input  logic                     real_scan_flag_i,
    input  logic                     pmt_scan_en_i,
    input  logic [CH_NUM-1:0]        fbc_up_en_i,
    input  logic [CH_NUM-1:0]        aurora_almost_full_i,
    output logic                     fbc_scan_en_o,
    output logic                     fbc_cache_vld_o,
    output logic [OUT_W-1:0]         fbc_cache_data_o,
    output logic [CH_NUM-1:0]        fbc_overflow_o
);
    localparam int REC_W = 16 + 2*ENC_W + DATA_W;
    localparam int PW    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    if (OUT_W < REC_W + 8) begin : g_bad_out_w
        $error("fbc_cache_arb: OUT_W too small for record + channel index");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH-1)) != 0) begin : g_bad_depth
        $error("fbc_cache_arb: DEPTH must be a power of two >= 2");
    end
    if (CH_NUM < 1 || CH_NUM > 8) begin : g_bad_ch
        $error("fbc_cache_arb: CH_NUM must be 1..8");
    end
    if (TCQ < 0.0) begin : g_bad_tcq
        $error("fbc_cache_arb: TCQ must be non-negative");
    end

    logic                           scan_en_q, scan_en_d, scan_prev_q;
    logic                           flush;
    logic [PW-1:0]                  ptr_q, ptr_d;
    logic [CH_NUM-1:0][15:0]        seq_q, seq_d;
    logic [CH_NUM-1:0]              ovf_q, ovf_d;
    logic                           vld_q, vld_d;
    logic [OUT_W-1:0]               data_q, data_d;
    logic [CH_NUM-1:0]              accept, empty, drop, elig, gnt;
    logic [CH_NUM-1:0][REC_W-1:0]   rec_in, rec_out;
    logic                           gnt_any;
    logic [PW-1:0]                  gnt_idx;

    assign scan_en_d = real_scan_flag_i & pmt_scan_en_i;
    // Rising edge of the registered scan enable flushes on the following edge.
    assign flush     = scan_en_q & ~scan_prev_q;
    assign elig      = ~empty & ~aurora_almost_full_i & {CH_NUM{~flush}};

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        assign accept[c] = fbc_vld_i[c] & fbc_up_en_i[c] & scan_en_q & ~flush;
        assign rec_in[c] = {seq_q[c], encode_w_i, encode_x_i,
                            fbc_data_i[c*DATA_W +: DATA_W]};
        fbc_cache_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .flush_i (flush),
            .push_i  (accept[c]),
            .pop_i   (gnt[c]),
            .din_i   (rec_in[c]),
            .dout_o  (rec_out[c]),
            .empty_o (empty[c]),
            .drop_o  (drop[c])
        );
    end

    // Round-robin grant: search from the channel after the last winner.
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        for (int i = 1; i <= CH_NUM; i++) begin
            idx = (int'(ptr_q) + i) % CH_NUM;
            if (!gnt_any && elig[idx]) begin
                gnt_any  = 1'b1;
                gnt_idx  = PW'(idx);
                gnt[idx] = 1'b1;
            end
        end
    end

    // Next state for pointer, counters, sticky flags and the output word.
    always_comb begin
        ptr_d  = gnt_any ? gnt_idx : ptr_q;
        vld_d  = gnt_any;
        data_d = data_q;
        if (gnt_any) begin
            data_d                = '0;
            data_d[REC_W-1:0]     = rec_out[gnt_idx];
            data_d[REC_W +: 8]    = 8'(gnt_idx);
        end
        for (int c = 0; c < CH_NUM; c++) begin
            seq_d[c] = flush ? 16'h0 : seq_q[c] + 16'(accept[c]);
            ovf_d[c] = flush ? 1'b0  : (ovf_q[c] | drop[c]);
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scan_en_q   <= 1'b0;
            scan_prev_q <= 1'b0;
            ptr_q       <= PW'(CH_NUM-1);
            seq_q       <= '0;
            ovf_q       <= '0;
            vld_q       <= 1'b0;
            data_q      <= '0;
        end else begin
            scan_en_q   <= scan_en_d;
            scan_prev_q <= scan_en_q;
            ptr_q       <= ptr_d;
            seq_q       <= seq_d;
            ovf_q       <= ovf_d;
            vld_q       <= vld_d;
            data_q      <= data_d;
        end
    end

    assign fbc_scan_en_o    = scan_en_q;
    assign fbc_cache_vld_o  = vld_q;
    assign fbc_cache_data_o = data_q;
    assign fbc_overflow_o   = ovf_q;
endmodule
